// File: rtl/passcode_controller.sv
// Keypad passcode lock: edge-detects key presses, buffers BCD digits and sequences
// LOCKED / OPEN / SET_NEW / LOCKOUT with auto-relock and failed-attempt lockout timers.
module passcode_controller #(
  parameter int unsigned         DIGITS         = 4,
  parameter logic [DIGITS*4-1:0] DEFAULT_CODE   = 16'h1234,
  parameter int unsigned         MAX_TRIES      = 3,
  parameter int unsigned         LOCKOUT_CYCLES = 1000,
  parameter int unsigned         OPEN_CYCLES    = 500
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         strobe,
  input  logic [4:0]                   key_code,
  output logic                         unlocked,
  output logic                         lockout,
  output logic                         setting,
  output logic                         error,
  output logic                         saved,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic [DIGITS*4-1:0]          entry_disp
);

  localparam int unsigned DW   = DIGITS * 4;
  localparam int unsigned CW   = $clog2(DIGITS + 1);
  localparam int unsigned TMAX = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned FW   = $clog2(MAX_TRIES + 1);

  localparam logic [CW-1:0] FULL   = CW'(DIGITS);
  localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYCLES);
  localparam logic [TW-1:0] T_LOCK = TW'(LOCKOUT_CYCLES);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [FW-1:0] F_MAX  = FW'(MAX_TRIES);
  localparam logic [FW-1:0] F_ONE  = FW'(1);

  typedef enum logic [1:0] {LOCKED, OPEN, SET_NEW, LOCKOUT} state_t;

  state_t        state;
  logic          strobe_q;
  logic [DW-1:0] stored;
  logic [TW-1:0] timer;
  logic [FW-1:0] fail_cnt;
  logic          key_evt, is_digit, is_enter, is_clear, is_set;
  logic [DW-1:0] shifted;

  always_comb begin
    key_evt  = strobe & ~strobe_q;
    is_digit = key_evt && (key_code < 5'd10);
    is_enter = key_evt && (key_code == 5'd16);
    is_clear = key_evt && (key_code == 5'd17);
    is_set   = key_evt && (key_code == 5'd18);
    shifted  = (entry_disp << 4) | DW'(key_code[3:0]);
  end

  // Mode outputs are written alongside every state change so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOCKED;
      strobe_q    <= 1'b0;
      entry_disp  <= '0;
      digit_count <= '0;
      fail_cnt    <= '0;
      timer       <= '0;
      stored      <= DEFAULT_CODE;
      unlocked    <= 1'b0;
      lockout     <= 1'b0;
      setting     <= 1'b0;
      error       <= 1'b0;
      saved       <= 1'b0;
    end else begin
      strobe_q <= strobe;
      error    <= 1'b0;
      saved    <= 1'b0;
      case (state)
        LOCKED: begin
          if (is_digit) begin
            if (digit_count != FULL) begin
              entry_disp  <= shifted;
              digit_count <= digit_count + CW'(1);
            end
          end else if (is_clear) begin
            entry_disp  <= '0;
            digit_count <= '0;
          end else if (is_enter) begin
            entry_disp  <= '0;
            digit_count <= '0;
            if (digit_count == FULL && entry_disp == stored) begin
              state    <= OPEN;
              unlocked <= 1'b1;
              fail_cnt <= '0;
              timer    <= T_OPEN;
            end else begin
              error <= 1'b1;
              if (fail_cnt + F_ONE == F_MAX) begin
                state    <= LOCKOUT;
                lockout  <= 1'b1;
                timer    <= T_LOCK;
                fail_cnt <= '0;
              end else begin
                fail_cnt <= fail_cnt + F_ONE;
              end
            end
          end
        end
        OPEN: begin
          if (is_enter) begin
            state    <= LOCKED;
            unlocked <= 1'b0;
          end else if (is_set) begin
            state       <= SET_NEW;
            setting     <= 1'b1;
            entry_disp  <= '0;
            digit_count <= '0;
          end else if (is_digit || is_clear) begin
            timer <= T_OPEN;
          end else if (timer <= T_ONE) begin
            state    <= LOCKED;
            unlocked <= 1'b0;
            timer    <= '0;
          end else begin
            timer <= timer - T_ONE;
          end
        end
        SET_NEW: begin
          if (is_digit) begin
            if (digit_count != FULL) begin
              entry_disp  <= shifted;
              digit_count <= digit_count + CW'(1);
            end
          end else if (is_clear) begin
            if (digit_count == '0) begin
              state   <= OPEN;
              setting <= 1'b0;
              timer   <= T_OPEN;
            end else begin
              entry_disp  <= '0;
              digit_count <= '0;
            end
          end else if (is_enter) begin
            entry_disp  <= '0;
            digit_count <= '0;
            if (digit_count == FULL) begin
              stored  <= entry_disp;
              saved   <= 1'b1;
              state   <= OPEN;
              setting <= 1'b0;
              timer   <= T_OPEN;
            end else begin
              error <= 1'b1;
            end
          end
        end
        LOCKOUT: begin
          if (timer <= T_ONE) begin
            state       <= LOCKED;
            lockout     <= 1'b0;
            timer       <= '0;
            entry_disp  <= '0;
            digit_count <= '0;
          end else begin
            timer <= timer - T_ONE;
          end
        end
        default: state <= LOCKED;
      endcase
    end
  end

endmodule

// File: doc/passcode_controller.md
Name: passcode_controller

Overview:
- Downstream consumer of the keypad synchroniser's `strobe`/`key_code` pair.
- Edge-detects each key press, decodes it, accumulates digits into an entry buffer and compares against a stored passcode.
- Drives the lock output, with an auto-relock timer, a failed-attempt lockout and a passcode-change mode.
- Sits between the keypad front end and the solenoid/LED/display drivers.

Parameters:
DIGITS, 4, passcode length in decimal digits (1..8)
DEFAULT_CODE, 16'h1234, BCD passcode loaded at reset; width DIGITS*4, most significant digit entered first
MAX_TRIES, 3, consecutive wrong ENTERs that trigger lockout (>=1)
LOCKOUT_CYCLES, 1000, clock cycles spent in LOCKOUT (>=1)
OPEN_CYCLES, 500, idle cycles in OPEN before automatic relock (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
strobe  input  1  key-held level from the synchroniser
key_code  input  5  key index, valid while strobe is high
unlocked  output  1  high in OPEN and SET_NEW
lockout  output  1  high in LOCKOUT
setting  output  1  high in SET_NEW
error  output  1  one-cycle pulse on a rejected ENTER
saved  output  1  one-cycle pulse when a new passcode is stored
digit_count  output  $clog2(DIGITS+1)  digits currently buffered
entry_disp  output  DIGITS*4  entry buffer, BCD, newest digit in bits [3:0]

Behaviour:
- Clocking and reset: single clock `clk`. Reset is synchronous, active-high, on `rst`. While `rst` is sampled high at a clock edge:
  - state = LOCKED; `strobe_q`=0; entry=0; `digit_count`=0.
  - fail_cnt=0; timer=0; stored=DEFAULT_CODE.
  - `unlocked`=`lockout`=`setting`=`error`=`saved`=0.
  - Reset mid-operation, including in SET_NEW, discards any new code and restores DEFAULT_CODE.
- Key event:
  - `strobe_q` registers `strobe`; key_evt = `strobe` & ~`strobe_q`.
  - `key_code` is sampled in the key_evt cycle. Effects are visible after the next clock edge (1-cycle latency).
  - A held key produces exactly one event. Re-pressing requires `strobe` low for at least one cycle.
- Decode:
  - 0..9 = DIGIT; 16 = ENTER; 17 = CLEAR; 18 = SET.
  - All other codes are ignored: no state change and no error.
- Digit accumulate (LOCKED, SET_NEW):
  - If `digit_count` < DIGITS: entry = {entry[DIGITS*4-5:0], digit}; `digit_count`++.
  - If `digit_count` == DIGITS: the digit is ignored silently.
  - CLEAR sets entry=0 and `digit_count`=0.
- States:
  - LOCKED:
    - ENTER with `digit_count`==DIGITS and entry==stored -> OPEN; fail_cnt=0; timer=OPEN_CYCLES; entry cleared.
    - Any other ENTER (short entry or mismatch) -> `error` pulse; entry cleared; fail_cnt++.
    - If the incremented fail_cnt==MAX_TRIES -> LOCKOUT; timer=LOCKOUT_CYCLES; fail_cnt=0.
    - SET is ignored.
  - OPEN:
    - Any decoded key event reloads timer=OPEN_CYCLES.
    - ENTER -> LOCKED (manual relock). SET -> SET_NEW with entry cleared. Digits and CLEAR are ignored apart from the timer reload.
    - With no event, timer decrements each cycle; on reaching 0 -> LOCKED.
    - A key event in the same cycle as timer==1 takes priority: timer reloads and the state stays OPEN.
  - SET_NEW:
    - Digits accumulate.
    - ENTER with `digit_count`==DIGITS -> stored=entry; `saved` pulse; -> OPEN; timer=OPEN_CYCLES; entry cleared.
    - ENTER with fewer digits -> `error` pulse; entry cleared; stay in SET_NEW.
    - CLEAR with `digit_count`==0 -> OPEN (abandon). CLEAR with `digit_count`>0 clears the entry only.
    - SET is ignored. No timeout.
  - LOCKOUT:
    - All key events are ignored, including one in the expiry cycle.
    - timer decrements each cycle; on 1->0 -> LOCKED with entry cleared.
    - Occupancy is exactly LOCKOUT_CYCLES cycles with `lockout` high.
- Outputs are registered and derived from state. `error` and `saved` are never high together.
- Width rules:
  - timer width = $clog2(max(LOCKOUT_CYCLES, OPEN_CYCLES)+1).
  - fail_cnt width = $clog2(MAX_TRIES+1).
  - No wrap-around in either counter.

Test Plan:
- Reset, press 1,2,3,4 (16'h1234), ENTER -> `entry_disp` steps 0001,0012,0123,1234; `unlocked`=1 one cycle after the ENTER edge; `digit_count`=0.
- Hold key 5 with `strobe` high for 20 cycles -> `digit_count`=1 only; release, press 5 again -> `digit_count`=2.
- MAX_TRIES=3: enter 9999+ENTER three times -> `error` pulses three times; `lockout`=1 for exactly LOCKOUT_CYCLES (test value 16) cycles; keys during lockout ignored; then LOCKED with `digit_count`=0.
- In OPEN: SET, then 5,6,7,8, ENTER -> `saved` pulse, `setting` 1->0; ENTER relocks; then 1234+ENTER -> `error`; 5678+ENTER -> `unlocked`.
- OPEN_CYCLES=10: no keys -> relock after 10 cycles; a key event on the last cycle -> stays open for 10 more cycles.
- Edge cases: press 3 digits + ENTER -> `error`; press 5 digits -> 5th ignored, `entry_disp`=1234; assert `rst` in SET_NEW after typing 5678 -> LOCKED, and 1234 unlocks.
